// File: rtl/sfo_sweep_controller_if.sv
// ---------------------------------------------------------------------------
// sfo_sweep_controller_if
//
// Purpose: bundles every signal of the SFO sweep controller except clk/reset.
//   The signals cover three groups:
//     - sweep control and settings (from the MRR gateway registers);
//     - the magnitude buffer read port;
//     - the correlator interface.
//   Sweep results are carried here as well.
//
// Modports:
//   master : the sweep controller
//   slave  : the environment (settings, buffer, correlator)
//
// Handshake semantics:
//   - start is a request level sampled on clk. It is accepted only in the
//     cycle the controller is idle, and is ignored at any other time.
//     busy rises the cycle after an accepted start and stays high until the
//     cycle after the sweep's final state. done is a single-cycle pulse in
//     that same cycle.
//   - buf_rd_en/buf_rd_addr address a RAM with 1-cycle read latency.
//     corr_update is buf_rd_en delayed by one cycle, so each corr_update
//     strobe marks one valid RAM data word at the correlator.
//   - corr_valid is a level from the correlator that is cleared by
//     corr_reset. Only the first cycle of corr_valid after each corr_reset
//     is consumed; corr_value is sampled in that cycle.
// ---------------------------------------------------------------------------
interface sfo_sweep_controller_if #(
  parameter int FFT_LEN_LOG2   = 9,
  parameter int SFO_INT_WIDTH  = 9,
  parameter int SFO_FRAC_WIDTH = 16,
  parameter int CORR_WIDTH     = 27,
  parameter int NUM_HYP_WIDTH  = 8
);
  logic                                    start;
  logic                                    abort;
  logic [SFO_INT_WIDTH-1:0]                sfo_start_int;
  logic [SFO_FRAC_WIDTH-1:0]               sfo_start_frac;
  logic [SFO_FRAC_WIDTH+SFO_INT_WIDTH-1:0] sfo_step_frac;
  logic [NUM_HYP_WIDTH-1:0]                num_hypotheses;
  logic                                    buf_rd_en;
  logic [FFT_LEN_LOG2-1:0]                 buf_rd_addr;
  logic [SFO_INT_WIDTH-1:0]                corr_sfo_int_part;
  logic [SFO_FRAC_WIDTH-1:0]               corr_sfo_frac_part;
  logic                                    corr_reset;
  logic                                    corr_update;
  logic                                    corr_valid;
  logic [CORR_WIDTH-1:0]                   corr_value;
  logic                                    busy;
  logic                                    done;
  logic [SFO_INT_WIDTH-1:0]                best_sfo_int;
  logic [SFO_FRAC_WIDTH-1:0]               best_sfo_frac;
  logic [CORR_WIDTH-1:0]                   best_corr;
  logic [NUM_HYP_WIDTH-1:0]                timeout_count;

  modport master (
    input  start, abort, sfo_start_int, sfo_start_frac, sfo_step_frac,
           num_hypotheses, corr_valid, corr_value,
    output buf_rd_en, buf_rd_addr, corr_sfo_int_part, corr_sfo_frac_part,
           corr_reset, corr_update, busy, done, best_sfo_int, best_sfo_frac,
           best_corr, timeout_count
  );

  modport slave (
    output start, abort, sfo_start_int, sfo_start_frac, sfo_step_frac,
           num_hypotheses, corr_valid, corr_value,
    input  buf_rd_en, buf_rd_addr, corr_sfo_int_part, corr_sfo_frac_part,
           corr_reset, corr_update, busy, done, best_sfo_int, best_sfo_frac,
           best_corr, timeout_count
  );
endinterface

// File: rtl/sfo_sweep_controller.sv
// ---------------------------------------------------------------------------
// sfo_sweep_controller
//
// Purpose: steps the SFO FFT correlator through a sweep of SFO hypotheses.
//   For each hypothesis it:
//     - programs the correlator's SFO value and pulses its reset;
//     - replays the buffered FFT-magnitude frame into it;
//     - captures the first result.
//   It keeps the best-scoring hypothesis, where ties keep the earlier one.
//
// Ports:
//   clk         : clock
//   reset       : asynchronous active-high reset
//   bus         : sfo_sweep_controller_if.master. It carries:
//                   - control and settings;
//                   - the magnitude buffer read port;
//                   - the correlator interface;
//                   - the results.
//   dbg_state_o : current FSM state
// ---------------------------------------------------------------------------
module sfo_sweep_controller #(
  parameter int FFT_LEN_LOG2   = 9,
  parameter int SFO_INT_WIDTH  = 9,
  parameter int SFO_FRAC_WIDTH = 16,
  parameter int CORR_WIDTH     = 27,
  parameter int NUM_HYP_WIDTH  = 8,
  parameter int DRAIN_TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  sfo_sweep_controller_if.master       bus,
  output logic [2:0]                   dbg_state_o
);

  localparam int SW  = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CRST   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_UPDATE = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            sfo_q;        // current hypothesis {int,frac}
  logic [SW-1:0]            step_q;
  logic [NUM_HYP_WIDTH-1:0] num_q;
  logic [NUM_HYP_WIDTH-1:0] hyp_cnt_q;
  logic [FFT_LEN_LOG2-1:0]  rd_addr_q;
  logic                     upd_q;        // buf_rd_en delayed to match RAM data
  logic                     captured_q;
  logic [CORR_WIDTH-1:0]    cap_val_q;
  logic [DCW-1:0]           drain_cnt_q;
  logic                     busy_q;
  logic                     done_q;
  logic [SW-1:0]            best_sfo_q;
  logic [CORR_WIDTH-1:0]    best_corr_q;
  logic [NUM_HYP_WIDTH-1:0] timeout_q;

  logic                     timeout_hit;
  logic                     cap_en;
  logic                     aborting;
  logic                     better;
  logic [NUM_HYP_WIDTH-1:0] hyp_next;

  assign aborting = bus.abort && (state_q != S_IDLE);
  assign hyp_next = hyp_cnt_q + 1'b1;
  // Hypothesis 0 always seeds the best; afterwards only a strictly larger
  // magnitude (threshold flag excluded) replaces it.
  assign better   = (hyp_cnt_q == '0) ||
                    (cap_val_q[CORR_WIDTH-2:0] > best_corr_q[CORR_WIDTH-2:0]);
  // The first valid after the correlator reset wins; later ones are ignored.
  assign cap_en   = bus.corr_valid && !captured_q && !aborting &&
                    (state_q != S_IDLE) && (state_q != S_CRST);

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.num_hypotheses == '0) ? S_FIN : S_CRST;
        end
      end
      S_CRST:   state_d = S_STREAM;
      S_STREAM: begin
        if (rd_addr_q == '1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // upd_q high means the final sample is still on its way in.
        if (!upd_q && captured_q) begin
          state_d = S_UPDATE;
        end else if (!captured_q && !bus.corr_valid &&
                     (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1))) begin
          // No result: cap_val_q was cleared in CRST, so it scores as zero.
          timeout_hit = 1'b1;
          state_d     = S_UPDATE;
        end
      end
      S_UPDATE: state_d = (hyp_next == num_q) ? S_FIN : S_CRST;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (aborting) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sfo_q       <= '0;
      step_q      <= '0;
      num_q       <= '0;
      hyp_cnt_q   <= '0;
      rd_addr_q   <= '0;
      upd_q       <= 1'b0;
      captured_q  <= 1'b0;
      cap_val_q   <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_sfo_q  <= '0;
      best_corr_q <= '0;
      timeout_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_FIN) && !aborting;
      upd_q   <= (state_q == S_STREAM) && !aborting;

      if (cap_en) begin
        captured_q <= 1'b1;
        cap_val_q  <= bus.corr_value;
      end

      if (!aborting) begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              sfo_q       <= {bus.sfo_start_int, bus.sfo_start_frac};
              step_q      <= bus.sfo_step_frac;
              num_q       <= bus.num_hypotheses;
              hyp_cnt_q   <= '0;
              best_sfo_q  <= '0;
              best_corr_q <= '0;
              timeout_q   <= '0;
            end
          end
          S_CRST: begin
            captured_q  <= 1'b0;
            cap_val_q   <= '0;
            drain_cnt_q <= '0;
            rd_addr_q   <= '0;
          end
          S_STREAM: rd_addr_q <= rd_addr_q + 1'b1;
          S_DRAIN: begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
            if (timeout_hit && (timeout_q != '1)) timeout_q <= timeout_q + 1'b1;
          end
          S_UPDATE: begin
            if (better) begin
              best_sfo_q  <= sfo_q;
              best_corr_q <= cap_val_q;
            end
            sfo_q     <= sfo_q + step_q;  // wraps modulo 2^SW
            hyp_cnt_q <= hyp_next;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.buf_rd_en          = (state_q == S_STREAM);
  assign bus.buf_rd_addr        = rd_addr_q;
  assign bus.corr_reset         = (state_q == S_CRST);
  assign bus.corr_update        = upd_q;
  assign bus.corr_sfo_int_part  = sfo_q[SW-1:SFO_FRAC_WIDTH];
  assign bus.corr_sfo_frac_part = sfo_q[SFO_FRAC_WIDTH-1:0];
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.best_sfo_int       = best_sfo_q[SW-1:SFO_FRAC_WIDTH];
  assign bus.best_sfo_frac      = best_sfo_q[SFO_FRAC_WIDTH-1:0];
  assign bus.best_corr          = best_corr_q;
  assign bus.timeout_count      = timeout_q;
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_sfo_sweep_controller.sv
// ---------------------------------------------------------------------------
// tb_sfo_sweep_controller
//
// Purpose: self-checking bench for sfo_sweep_controller with N=16.
//   A correlator model answers each hypothesis as directed by per-hypothesis
//   mode/value tables:
//     - normal: valid after the 16th update;
//     - never:  no valid at all;
//     - early:  0x123 at update 5, then the value changes randomly.
//   A reference model computes the expected:
//     - SFO sequence;
//     - address stream;
//     - update count;
//     - final result.
//   It derives these from start/step/num with plain arithmetic and queues
//   them. A monitor pops and compares whenever the DUT presents corr_reset,
//   buf_rd_en or done.
// ---------------------------------------------------------------------------
module tb_sfo_sweep_controller;
  localparam int FL = 4;
  localparam int IW = 9;
  localparam int FW = 16;
  localparam int CW = 27;
  localparam int NW = 8;
  localparam int SW = IW + FW;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfo_sweep_controller_if #(.FFT_LEN_LOG2(FL), .SFO_INT_WIDTH(IW),
    .SFO_FRAC_WIDTH(FW), .CORR_WIDTH(CW), .NUM_HYP_WIDTH(NW)) bus ();
  logic [2:0] dbg_state;

  sfo_sweep_controller #(.FFT_LEN_LOG2(FL), .SFO_INT_WIDTH(IW),
    .SFO_FRAC_WIDTH(FW), .CORR_WIDTH(CW), .NUM_HYP_WIDTH(NW),
    .DRAIN_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .dbg_state_o(dbg_state)
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [SW-1:0]         sfo_exp_q[$];
  logic [FL-1:0]         addr_exp_q[$];
  logic [SW+CW+NW-1:0]   res_exp_q[$];
  logic [15:0]           upd_exp_q[$];
  bit                    sb_en = 1'b0;
  int                    done_total = 0;
  int                    upd_seen = 0;

  // correlator model control: mode 0 normal, 1 never valid, 2 early valid
  logic [CW-1:0] hyp_val [16];
  logic [1:0]    hyp_mode[16];
  int            rst_cnt = 0;
  int            cur_h = 0;
  int            upd_n = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic monitor_loop();
    logic [SW+CW+NW-1:0] r;
    forever begin
      @(negedge clk);
      if (bus.done) done_total++;
      if (sb_en && !reset) begin
        if (bus.corr_reset) begin
          check("corr_reset_expected", 64'(sfo_exp_q.size() != 0), 64'd1);
          if (sfo_exp_q.size() != 0)
            check("corr_sfo", 64'({bus.corr_sfo_int_part, bus.corr_sfo_frac_part}),
                  64'(sfo_exp_q.pop_front()));
        end
        if (bus.buf_rd_en) begin
          check("rd_expected", 64'(addr_exp_q.size() != 0), 64'd1);
          if (addr_exp_q.size() != 0)
            check("buf_rd_addr", 64'(bus.buf_rd_addr), 64'(addr_exp_q.pop_front()));
        end
        if (bus.corr_update) upd_seen++;
        if (bus.done) begin
          check("done_expected", 64'(res_exp_q.size() != 0), 64'd1);
          if (res_exp_q.size() != 0) begin
            r = res_exp_q.pop_front();
            check("best_sfo", 64'({bus.best_sfo_int, bus.best_sfo_frac}),
                  64'(r[SW+CW+NW-1:CW+NW]));
            check("best_corr", 64'(bus.best_corr), 64'(r[CW+NW-1:NW]));
            check("timeout_count", 64'(bus.timeout_count), 64'(r[NW-1:0]));
          end
          if (upd_exp_q.size() != 0)
            check("update_count", 64'(upd_seen), 64'(upd_exp_q.pop_front()));
          upd_seen = 0;
        end
      end
    end
  endtask

  task automatic model_loop();
    logic was_valid;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.corr_valid = 1'b0;
        bus.corr_value = '0;
        rst_cnt = 0;
        upd_n = 0;
      end else if (bus.corr_reset) begin
        cur_h = rst_cnt % 16;
        rst_cnt++;
        upd_n = 0;
        bus.corr_valid = 1'b0;
        bus.corr_value = '0;
      end else begin
        if (!bus.busy) rst_cnt = 0;
        was_valid = bus.corr_valid;
        if (was_valid && hyp_mode[cur_h] == 2'd2) bus.corr_value = CW'($urandom);
        if (bus.corr_update) begin
          upd_n++;
          if (hyp_mode[cur_h] == 2'd2 && upd_n == 5) begin
            bus.corr_valid = 1'b1;
            bus.corr_value = CW'(27'h123);
          end
          if (hyp_mode[cur_h] == 2'd0 && upd_n == 16) begin
            bus.corr_valid = 1'b1;
            bus.corr_value = hyp_val[cur_h];
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({bus.buf_rd_en, bus.buf_rd_addr, bus.corr_reset,
          bus.corr_update, bus.busy, bus.done, bus.corr_sfo_int_part,
          bus.corr_sfo_frac_part}), 64'd0);
    check({tag, "_result"}, 64'({bus.best_sfo_int, bus.best_sfo_frac,
          bus.best_corr, bus.timeout_count}), 64'd0);
  endtask

  // driver: one start pulse with the given configuration
  task automatic start_pulse(input logic [IW-1:0] s_int, input logic [FW-1:0] s_frac,
                             input logic [SW-1:0] step, input logic [NW-1:0] num);
    bus.sfo_start_int  = s_int;
    bus.sfo_start_frac = s_frac;
    bus.sfo_step_frac  = step;
    bus.num_hypotheses = num;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_rd_addr(input logic [FL-1:0] a, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.buf_rd_en && bus.buf_rd_addr == a) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 64'(seen), 64'd1);
  endtask

  // reference model + driver + bounded wait for done
  task automatic run_sweep(input logic [IW-1:0] s_int, input logic [FW-1:0] s_frac,
                           input logic [SW-1:0] step, input logic [NW-1:0] num,
                           input bit poke, output int cycles);
    logic [SW-1:0] sfo, bs;
    logic [CW-1:0] bv, v;
    logic [NW-1:0] to;
    bit got;
    int d0;
    sfo = {s_int, s_frac};
    bs = '0; bv = '0; to = '0;
    for (int h = 0; h < int'(num); h++) begin
      case (hyp_mode[h])
        2'd1: begin v = '0; if (to != '1) to = to + 1'b1; end
        2'd2: v = CW'(27'h123);
        default: v = hyp_val[h];
      endcase
      sfo_exp_q.push_back(sfo);
      for (int a = 0; a < 16; a++) addr_exp_q.push_back(FL'(a));
      if (h == 0 || v[CW-2:0] > bv[CW-2:0]) begin
        bv = v;
        bs = sfo;
      end
      sfo = sfo + step;
    end
    res_exp_q.push_back({bs, bv, to});
    upd_exp_q.push_back(16'(16 * int'(num)));

    d0 = done_total;
    bus.sfo_start_int  = s_int;
    bus.sfo_start_frac = s_frac;
    bus.sfo_step_frac  = step;
    bus.num_hypotheses = num;
    bus.start = 1'b1;
    got = 1'b0;
    cycles = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      cycles = c;
      // settings are latched at start, so scramble them afterwards
      bus.sfo_start_int  = IW'($urandom);
      bus.sfo_start_frac = FW'($urandom);
      bus.sfo_step_frac  = SW'($urandom);
      bus.num_hypotheses = NW'($urandom);
      bus.start = poke && (c == 5);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    check("busy_at_done", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("sb_drained", 64'(sfo_exp_q.size() + addr_exp_q.size() +
          res_exp_q.size() + upd_exp_q.size()), 64'd0);
    check("done_pulses", 64'(done_total - d0), 64'd1);
  endtask

  task automatic clear_hyps();
    for (int h = 0; h < 16; h++) begin
      hyp_mode[h] = 2'd0;
      hyp_val[h]  = CW'($urandom);
    end
  endtask

  initial begin
    int cyc;
    int d0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sfo_start_int = '0;
    bus.sfo_start_frac = '0;
    bus.sfo_step_frac = '0;
    bus.num_hypotheses = '0;
    bus.corr_valid = 1'b0;
    bus.corr_value = '0;
    clear_hyps();
    fork
      monitor_loop();
      model_loop();
      watchdog();
    join_none

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 reset = 1'b0;
    @(negedge clk);
    sb_en = 1'b1;

    // basic sweep + best tracking; hyp 2 ties hyp 1 in magnitude, flag set
    clear_hyps();
    hyp_val[0] = CW'(10);
    hyp_val[1] = CW'(40);
    hyp_val[2] = {1'b1, 26'd40};
    hyp_val[3] = CW'(5);
    run_sweep(9'd3, 16'h0000, 25'h0_8000, 8'd4, 1'b1, cyc);
    check("basic_best_corr", 64'(bus.best_corr), 64'd40);
    check("basic_best_sfo", 64'({bus.best_sfo_int, bus.best_sfo_frac}),
          64'({9'd3, 16'h8000}));

    // timeout on hypothesis 2 of 3
    clear_hyps();
    hyp_mode[1] = 2'd1;
    run_sweep(9'd20, 16'h1234, 25'h1_0100, 8'd3, 1'b0, cyc);
    check("timeout_count_1", 64'(bus.timeout_count), 64'd1);

    // early valid
    clear_hyps();
    hyp_mode[0] = 2'd2;
    run_sweep(9'd7, 16'h0000, 25'h0_1000, 8'd1, 1'b0, cyc);
    check("early_capture", 64'(bus.best_corr), 64'h123);

    // zero hypotheses
    clear_hyps();
    run_sweep(9'd5, 16'h5555, 25'h0_1000, 8'd0, 1'b0, cyc);
    check("num0_latency", 64'(cyc), 64'd2);
    check("num0_best_corr", 64'(bus.best_corr), 64'd0);

    // wrap of {int,frac}
    clear_hyps();
    run_sweep(9'd511, 16'hC000, 25'h0_4000, 8'd3, 1'b0, cyc);

    // abort mid-STREAM at address 7
    sb_en = 1'b0;
    clear_hyps();
    d0 = done_total;
    start_pulse(9'd1, 16'h0, 25'h0_8000, 8'd4);
    wait_rd_addr(4'd7, "abort_reach_addr7");
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_rd_en", 64'(bus.buf_rd_en), 64'd0);
    check("abort_update", 64'(bus.corr_update), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    repeat (30) @(negedge clk);
    check("abort_no_done", 64'(done_total - d0), 64'd0);
    check("abort_stays_idle", 64'(bus.buf_rd_en | bus.corr_reset | bus.busy), 64'd0);

    // async reset mid-DRAIN (hypothesis 0 never answers)
    clear_hyps();
    hyp_mode[0] = 2'd1;
    start_pulse(9'd2, 16'h0, 25'h0_8000, 8'd2);
    wait_rd_addr(4'd15, "reset_reach_addr15");
    repeat (5) @(negedge clk);
    check("drain_busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    sb_en = 1'b1;
    clear_hyps();
    run_sweep(9'd100, 16'h0F0F, 25'h0_2000, 8'd3, 1'b0, cyc);

    // randomized sweeps
    for (int it = 0; it < 10; it++) begin
      int num;
      int r;
      num = $urandom_range(1, 6);
      for (int h = 0; h < 16; h++) begin
        r = $urandom_range(0, 9);
        hyp_mode[h] = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : 2'd0;
        if ($urandom_range(0, 2) == 0)
          hyp_val[h] = {1'($urandom), 26'($urandom_range(0, 3))};
        else
          hyp_val[h] = CW'($urandom);
      end
      run_sweep(IW'($urandom), FW'($urandom), SW'($urandom), NW'(num),
                1'($urandom), cyc);
    end

    $display("final debug state %0d", dbg_state);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfo_sweep_controller.md
Name: sfo_sweep_controller

Overview:
- Sequences the SFO FFT correlator across a sweep of SFO hypotheses for one CFO hypothesis.
- For each hypothesis it:
  - programs the correlator's SFO int/frac inputs;
  - pulses the correlator reset;
  - replays the buffered FFT-magnitude frame from a 1-cycle-latency RAM into the correlator;
  - collects the correlation result.
- Tracks the best-scoring hypothesis and reports it when the sweep completes.
- Sits between the MRR gateway settings registers, the FFT magnitude buffer and the correlator.

Parameters:
- FFT_LEN_LOG2, 9: log2 of frame length; frame is 2^FFT_LEN_LOG2 bins.
- SFO_INT_WIDTH, 9: width of the SFO integer part.
- SFO_FRAC_WIDTH, 16: width of the SFO fractional part.
- CORR_WIDTH, 27: correlator output width; MSB is the threshold flag, remaining bits are the magnitude.
- NUM_HYP_WIDTH, 8: width of the hypothesis count.
- DRAIN_TIMEOUT, 64: cycles to wait after the last update before declaring no result.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  begin sweep; ignored unless idle
- abort  in  1  synchronous abort; return to IDLE, no done pulse
- sfo_start_int  in  SFO_INT_WIDTH  first hypothesis, integer part
- sfo_start_frac  in  SFO_FRAC_WIDTH  first hypothesis, fractional part
- sfo_step_frac  in  SFO_FRAC_WIDTH+SFO_INT_WIDTH  per-hypothesis increment, fixed point {int,frac}
- num_hypotheses  in  NUM_HYP_WIDTH  number of hypotheses to evaluate
- buf_rd_en  out  1  magnitude buffer read enable
- buf_rd_addr  out  FFT_LEN_LOG2  magnitude buffer address
- corr_sfo_int_part  out  SFO_INT_WIDTH  to correlator
- corr_sfo_frac_part  out  SFO_FRAC_WIDTH  to correlator
- corr_reset  out  1  correlator reset pulse
- corr_update  out  1  correlator sample strobe
- corr_valid  in  1  correlator result valid; level, cleared by corr_reset
- corr_value  in  CORR_WIDTH  correlator result
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- best_sfo_int  out  SFO_INT_WIDTH  best hypothesis, integer part
- best_sfo_frac  out  SFO_FRAC_WIDTH  best hypothesis, fractional part
- best_corr  out  CORR_WIDTH  best correlator value, including its flag
- timeout_count  out  NUM_HYP_WIDTH  number of hypotheses that timed out in the last sweep

Behaviour:
Reset:
- All outputs are 0 and state is IDLE.
- The async reset overrides any operation in progress.
- best_* and timeout_count hold their values until the next accepted start.

States: IDLE, CRST, STREAM, DRAIN, UPDATE, FIN.
- IDLE:
  - On start, latch all config inputs.
  - Load corr_sfo_* from sfo_start_*; clear best_* and timeout_count; set the hypothesis counter to 0.
  - busy=1 from the next cycle until FIN exits.
  - If num_hypotheses==0, go to FIN; else go to CRST.
- CRST (1 cycle):
  - corr_reset=1; corr_sfo_* are already stable, having been registered in the prior cycle.
  - Clear the captured flag, capture register and drain counter.
- STREAM:
  - buf_rd_en=1 for exactly 2^FFT_LEN_LOG2 cycles with buf_rd_addr=0..N-1 ascending.
  - corr_update is buf_rd_en delayed 1 cycle, so exactly N update pulses occur, aligned with RAM data.
  - Then go to DRAIN.
- Capture rule:
  - In any state except IDLE/CRST, the first cycle with corr_valid=1 latches corr_value and sets the captured flag.
  - Later cycles are ignored, which also covers the correlator finishing early mid-STREAM.
- DRAIN:
  - Wait for the final corr_update, then for captured=1, then go to UPDATE.
  - The drain counter counts DRAIN cycles. On reaching DRAIN_TIMEOUT without capture, treat the result as all-zeros, increment timeout_count (saturating), and go to UPDATE.
- UPDATE (1 cycle):
  - Compare magnitudes, i.e. corr_value[CORR_WIDTH-2:0].
  - The result replaces best_* if strictly greater, or if this is hypothesis 0. Ties keep the earlier hypothesis.
  - Advance the hypothesis: {int,frac} += sfo_step_frac, wrapping modulo 2^(SFO_INT_WIDTH+SFO_FRAC_WIDTH).
  - Increment the counter. If counter==num_hypotheses go to FIN, else go to CRST.
- FIN (1 cycle): done=1, busy=0 next cycle, go to IDLE.

Abort and restart:
- abort in any non-IDLE state: go to IDLE next cycle, with buf_rd_en, corr_update and busy deasserted.
- abort has priority over a simultaneous corr_valid or state transition.
- best_* are undefined after an abort.
- start while busy is ignored.
- start in the same cycle as FIN is ignored; a new start is accepted from the IDLE cycle onward.

Per-hypothesis latency: 1 (CRST) + N (STREAM) + 1 (final update) + drain (≤ DRAIN_TIMEOUT) + 1 (UPDATE).

Test Plan:
All scenarios use FFT_LEN_LOG2=4 (N=16) and a correlator model.
- Basic sweep, start=(int 3, frac 0), step=0x0_8000 (0.5), num=4:
  - corr_sfo_* sequence is 3.0, 3.5, 4.0, 4.5.
  - Per hypothesis: 16 addresses 0..15 and 16 corr_update pulses.
  - Exactly one done pulse.
- Best tracking, model returns magnitudes 10, 40, 40, 5:
  - best_corr magnitude is 40; best_sfo is hypothesis 1 (the tie keeps the earlier one).
- Timeout, model never asserts valid on hypothesis 2 of 3:
  - That hypothesis takes 64 drain cycles and counts as zero; timeout_count=1.
  - The sweep completes.
- Early valid, model asserts valid at update 5 with value 0x123:
  - Captured value is 0x123 even though valid stays high; STREAM still issues all 16 reads.
- num_hypotheses=0:
  - done pulses 2 cycles after start; no corr_reset, no reads; best_corr=0.
- Abort and async reset mid-STREAM (address 7):
  - abort: idle next cycle, no done, buf_rd_en=0.
  - Async reset mid-DRAIN: outputs immediately 0; a new start then works normally.
- Wrap: start int=511, frac=0xC000, step=0x0_4000:
  - Second hypothesis is int 0, frac 0x0000.
